// File: rtl/ble_conn_event_seq.sv
// BLE connection-event sequencer: picks the data channel with Channel Selection
// Algorithm #1, then drives back-to-back TX / T_IFS / RX / T_IFS windows until stopped.
module ble_conn_event_seq #(
    parameter int TX_RX_COUNT = 625,
    parameter int TIFS_COUNT  = 150,
    parameter int CNT_W       = 10
) (
    input  logic        clock,
    input  logic        rst,
    input  logic        start,
    input  logic        stop,
    input  logic        tx_flag,
    input  logic [4:0]  hop_inc,
    input  logic [36:0] chan_map,
    output logic [5:0]  channel_index,
    output logic        channel_valid,
    output logic        ble_tx,
    output logic        ble_rx,
    output logic        ble_tifs,
    output logic        busy
);

    typedef enum logic [2:0] {
        S_IDLE, S_HOP, S_REMAP, S_PH_A, S_TIFS_1, S_PH_B, S_TIFS_2
    } state_t;

    state_t             state_r;
    logic               tx_flag_r;
    logic [4:0]         hop_inc_r;
    logic [36:0]        chan_map_r;
    logic [5:0]         last_unmapped_r;
    logic [5:0]         remap_index_r;
    logic [5:0]         scan_j_r;
    logic [5:0]         used_cnt_r;
    logic [CNT_W-1:0]   cnt_r;
    logic               stop_pend_r;

    logic [6:0]         sum_s;
    logic [6:0]         wrap_s;
    logic [5:0]         unmapped_s;
    logic [5:0]         num_used_s;
    logic [5:0]         remap_s;
    logic               last_txrx_s;
    logic               last_tifs_s;

    function automatic logic [5:0] popcount37(input logic [36:0] v);
        logic [5:0] n;
        n = 6'd0;
        for (int i = 0; i < 37; i++) begin
            n = n + {5'd0, v[i]};
        end
        return n;
    endfunction

    function automatic logic map_bit(input logic [36:0] m, input logic [5:0] idx);
        logic b;
        if (idx < 6'd37) begin
            b = m[idx];
        end else begin
            b = 1'b0;
        end
        return b;
    endfunction

    // Hop arithmetic and remap index for the channel being selected
    always_comb begin
        sum_s      = {1'b0, last_unmapped_r} + {2'b00, hop_inc_r};
        if (sum_s >= 7'd37) begin
            wrap_s = sum_s - 7'd37;
        end else begin
            wrap_s = sum_s;
        end
        if (wrap_s <= 7'd36) begin
            unmapped_s = wrap_s[5:0];
        end else begin
            unmapped_s = 6'd0;
        end
        num_used_s = popcount37(chan_map_r);
        if (num_used_s == 6'd0) begin
            remap_s = 6'd0;
        end else begin
            remap_s = unmapped_s % num_used_s;
        end
        last_txrx_s = (cnt_r == CNT_W'(TX_RX_COUNT - 1));
        last_tifs_s = (cnt_r == CNT_W'(TIFS_COUNT - 1));
    end

    // Event FSM with registered phase strobes
    always_ff @(posedge clock) begin
        if (rst) begin
            state_r         <= S_IDLE;
            tx_flag_r       <= 1'b0;
            hop_inc_r       <= 5'd0;
            chan_map_r      <= 37'd0;
            last_unmapped_r <= 6'd0;
            remap_index_r   <= 6'd0;
            scan_j_r        <= 6'd0;
            used_cnt_r      <= 6'd0;
            cnt_r           <= {CNT_W{1'b0}};
            stop_pend_r     <= 1'b0;
            channel_index   <= 6'd0;
            channel_valid   <= 1'b0;
            ble_tx          <= 1'b0;
            ble_rx          <= 1'b0;
            ble_tifs        <= 1'b0;
            busy            <= 1'b0;
        end else begin
            if (state_r != S_IDLE && stop) begin
                stop_pend_r <= 1'b1;
            end
            case (state_r)
                S_IDLE: begin
                    if (start) begin
                        tx_flag_r  <= tx_flag;
                        hop_inc_r  <= hop_inc;
                        chan_map_r <= chan_map;
                        busy       <= 1'b1;
                        state_r    <= S_HOP;
                    end
                end
                S_HOP: begin
                    last_unmapped_r <= unmapped_s;
                    if (map_bit(chan_map_r, unmapped_s) || num_used_s == 6'd0) begin
                        channel_index <= unmapped_s;
                        channel_valid <= 1'b1;
                        ble_tx        <= tx_flag_r;
                        ble_rx        <= ~tx_flag_r;
                        cnt_r         <= {CNT_W{1'b0}};
                        state_r       <= S_PH_A;
                    end else begin
                        remap_index_r <= remap_s;
                        scan_j_r      <= 6'd0;
                        used_cnt_r    <= 6'd0;
                        state_r       <= S_REMAP;
                    end
                end
                S_REMAP: begin
                    if (map_bit(chan_map_r, scan_j_r) && used_cnt_r == remap_index_r) begin
                        channel_index <= scan_j_r;
                        channel_valid <= 1'b1;
                        ble_tx        <= tx_flag_r;
                        ble_rx        <= ~tx_flag_r;
                        cnt_r         <= {CNT_W{1'b0}};
                        state_r       <= S_PH_A;
                    end else begin
                        used_cnt_r <= used_cnt_r + {5'd0, map_bit(chan_map_r, scan_j_r)};
                        scan_j_r   <= scan_j_r + 6'd1;
                    end
                end
                S_PH_A, S_PH_B: begin
                    if (last_txrx_s) begin
                        ble_tx   <= 1'b0;
                        ble_rx   <= 1'b0;
                        ble_tifs <= 1'b1;
                        cnt_r    <= {CNT_W{1'b0}};
                        state_r  <= (state_r == S_PH_A) ? S_TIFS_1 : S_TIFS_2;
                    end else begin
                        cnt_r <= cnt_r + CNT_W'(1);
                    end
                end
                S_TIFS_1, S_TIFS_2: begin
                    if (last_tifs_s && stop_pend_r) begin
                        stop_pend_r   <= 1'b0;
                        ble_tifs      <= 1'b0;
                        channel_valid <= 1'b0;
                        busy          <= 1'b0;
                        state_r       <= S_IDLE;
                    end else if (last_tifs_s) begin
                        // PH_B swaps direction relative to PH_A
                        ble_tifs <= 1'b0;
                        ble_tx   <= (state_r == S_TIFS_1) ? ~tx_flag_r : tx_flag_r;
                        ble_rx   <= (state_r == S_TIFS_1) ? tx_flag_r : ~tx_flag_r;
                        cnt_r    <= {CNT_W{1'b0}};
                        state_r  <= (state_r == S_TIFS_1) ? S_PH_B : S_PH_A;
                    end else begin
                        cnt_r <= cnt_r + CNT_W'(1);
                    end
                end
                default: begin
                    stop_pend_r   <= 1'b0;
                    channel_valid <= 1'b0;
                    ble_tx        <= 1'b0;
                    ble_rx        <= 1'b0;
                    ble_tifs      <= 1'b0;
                    busy          <= 1'b0;
                    state_r       <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ble_conn_event_seq.sv
// Self-checking bench for ble_conn_event_seq: event-level reference model (CSA#1 over a
// used-channel list, windows derived from a period timeline) compared every cycle.
module tb_ble_conn_event_seq;

    localparam int L = 10;
    localparam int T = 3;
    localparam logic [36:0] FULL_MAP = 37'h1F_FFFF_FFFF;

    logic        clock = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic        tx_flag = 1'b0;
    logic [4:0]  hop_inc = 5'd0;
    logic [36:0] chan_map = 37'd0;
    logic [5:0]  channel_index;
    logic        channel_valid, ble_tx, ble_rx, ble_tifs, busy;

    int n_checks = 0;
    int n_errors = 0;
    int m_last = 0;

    ble_conn_event_seq #(.TX_RX_COUNT(L), .TIFS_COUNT(T), .CNT_W(4)) dut (
        .clock(clock), .rst(rst), .start(start), .stop(stop), .tx_flag(tx_flag),
        .hop_inc(hop_inc), .chan_map(chan_map), .channel_index(channel_index),
        .channel_valid(channel_valid), .ble_tx(ble_tx), .ble_rx(ble_rx),
        .ble_tifs(ble_tifs), .busy(busy)
    );

    always #5 clock = ~clock;

    // CSA#1: returns channel and number of remap cycles (0 on a direct hit)
    task automatic model_channel(input logic [36:0] map, input logic [4:0] hop,
                                 output int ch, output int rlen);
        int u;
        int used[$];
        u = m_last + int'(hop);
        if (u >= 37) u -= 37;
        m_last = u;
        for (int i = 0; i < 37; i++) if (map[i]) used.push_back(i);
        if (map[u] || used.size() == 0) begin
            ch = u; rlen = 0;
        end else begin
            ch = used[u % used.size()]; rlen = ch + 1;
        end
    endtask

    task automatic check_all_zero(input string name);
        n_checks++;
        if ({busy, channel_valid, ble_tx, ble_rx, ble_tifs} !== 5'b0 || channel_index !== 6'd0) begin
            n_errors++;
            $display("FAIL %s: outputs %b idx %0d, required 00000 idx 0", name,
                     {busy, channel_valid, ble_tx, ble_rx, ble_tifs}, channel_index);
        end
    endtask

    task automatic do_reset();
        @(negedge clock); rst = 1'b1; start = 1'b0; stop = 1'b0;
        @(negedge clock); check_all_zero("reset_state");
        rst = 1'b0; m_last = 0;
    endtask

    // One event: start at cycle 0, optional stop/injected start/reset at given cycles
    task automatic run_event(input logic txf, input logic [4:0] hop, input logic [36:0] map,
                             input int stop_at, input logic stop_with_start,
                             input int start_at, input int rst_at);
        int ch, rlen, p0, e, base, per, q;
        logic [4:0] exp_v, got_v;
        model_channel(map, hop, ch, rlen);
        p0 = 2 + rlen; per = L + T; base = p0 + L + T - 1;
        if (stop_at + 1 <= base) e = base;
        else e = base + ((stop_at + 1 - base + per - 1) / per) * per;
        @(negedge clock);
        start = 1'b1; tx_flag = txf; hop_inc = hop; chan_map = map; stop = stop_with_start;
        for (int c = 1; c <= e + 1; c++) begin
            @(negedge clock);
            start = 1'b0; stop = 1'b0;
            tx_flag = 1'($urandom); hop_inc = 5'($urandom); chan_map = {5'($urandom), 32'($urandom)};
            if (rst_at > 0 && c == rst_at + 1) begin
                check_all_zero("reset_mid_event");
                rst = 1'b0; m_last = 0;
                return;
            end
            if (c > e) exp_v = 5'b00000;
            else if (c < p0) exp_v = 5'b10000;
            else begin
                q = (c - p0) % (2 * per);
                if (q < L)             exp_v = {2'b11, txf, ~txf, 1'b0};
                else if (q < per)      exp_v = 5'b11001;
                else if (q < per + L)  exp_v = {2'b11, ~txf, txf, 1'b0};
                else                   exp_v = 5'b11001;
            end
            got_v = {busy, channel_valid, ble_tx, ble_rx, ble_tifs};
            n_checks++;
            if (got_v !== exp_v) begin
                n_errors++;
                $display("FAIL window cycle %0d: {busy,valid,tx,rx,tifs}=%b required %b", c, got_v, exp_v);
            end
            if (c >= p0) begin
                n_checks++;
                if (channel_index !== 6'(ch)) begin
                    n_errors++;
                    $display("FAIL channel cycle %0d: got %0d required %0d", c, channel_index, ch);
                end
            end
            if (c == stop_at) stop = 1'b1;
            if (c == start_at && c <= e) start = 1'b1;
            if (c == rst_at) rst = 1'b1;
        end
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clock);
            start = 1'b0; stop = 1'($urandom);
            n_checks++;
            if (busy !== 1'b0) begin
                n_errors++;
                $display("FAIL idle_busy: busy=%b required 0", busy);
            end
        end
        @(negedge clock); stop = 1'b0;
    endtask

    task automatic check_index(input string name, input int exp_ch);
        n_checks++;
        if (channel_index !== 6'(exp_ch)) begin
            n_errors++;
            $display("FAIL %s: channel_index=%0d required %0d", name, channel_index, exp_ch);
        end
    endtask

    task automatic test_reset();
        do_reset();
    endtask

    task automatic test_windows();
        run_event(1'b1, 5'd7, FULL_MAP, 75, 1'b0, 0, 0);
    endtask

    task automatic test_hop_sequence();
        int tbl[6] = '{7, 14, 21, 28, 35, 5};
        do_reset();
        for (int i = 0; i < 6; i++) begin
            run_event(1'b1, 5'd7, FULL_MAP, 3, 1'b0, 0, 0);
            check_index("hop_sequence", tbl[i]);
        end
    endtask

    task automatic test_remap();
        do_reset();
        run_event(1'b1, 5'd12, 37'h3FF, 10, 1'b0, 0, 0);
        check_index("remap_3ff", 2);
    endtask

    task automatic test_stop();
        do_reset();
        // stop mid PH_B of the first period: ends after TIFS_2
        run_event(1'b0, 5'd9, FULL_MAP, 2 + L + T + 5, 1'b0, 0, 0);
        // stop mid PH_A: ends after TIFS_1; stop with start is discarded
        run_event(1'b0, 5'd6, FULL_MAP, 2 + 4 + 2 * (L + T), 1'b1, 0, 0);
    endtask

    task automatic test_reset_mid();
        run_event(1'b1, 5'd11, FULL_MAP, 1000, 1'b0, 0, 2 + L + T + 4);
        run_event(1'b1, 5'd5, FULL_MAP, 4, 1'b0, 0, 0);
        check_index("after_reset_hop5", 5);
    endtask

    task automatic test_start_ignored();
        do_reset();
        run_event(1'b1, 5'd9, 37'd0, 30, 1'b0, 5, 0);
        check_index("empty_map", 9);
    endtask

    task automatic test_random();
        logic [36:0] map;
        for (int k = 0; k < 20; k++) begin
            case ($urandom_range(0, 3))
                0: map = FULL_MAP;
                1: map = {5'($urandom), 32'($urandom)};
                2: map = {5'($urandom), 32'($urandom)} & {5'($urandom), 32'($urandom)}
                         & {5'($urandom), 32'($urandom)};
                default: map = 37'd0;
            endcase
            run_event(1'($urandom), 5'($urandom_range(5, 16)), map, $urandom_range(1, 70),
                      1'($urandom), $urandom_range(1, 40), 0);
            idle_cycles($urandom_range(1, 4));
        end
    endtask

    initial begin
        test_reset();
        test_windows();
        test_hop_sequence();
        test_remap();
        test_stop();
        test_reset_mid();
        test_start_ignored();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
